cache_main_mem: RTL and testbench

Main-memory responder on the far side of the direct-mapped cache's memory interface. Accepts line-granular read (refill) and write (write-back) requests from the cache controller as `mem_req_type`, and answers with `mem_data_type` after a fixed, parameterised latency. Holds a 128-bit-line backing store. Serves as the synthesizable memory model for cache integration and simulation.

---
 rtl/cache_def.sv | 26 ++
 rtl/main_mem_array.sv | 27 ++
 rtl/cache_main_mem.sv | 99 +++++++++
 tb/tb_cache_main_mem.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared definitions for the cache and its main-memory port: request and
// response structs, line geometry and the memory responder's state type.
package cache_def;

  localparam int LINE_BYTES_LOG2 = 4;
  localparam int LINE_BITS       = 128;

  typedef struct packed {
    logic [31:0]          addr;
    logic [LINE_BITS-1:0] data;
    logic                 rw;     // 1 = write-back, 0 = refill
    logic                 valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_BITS-1:0] data;
    logic                 ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_type;

endpackage

// File: rtl/main_mem_array.sv
// Backing store for the main-memory model: one 128-bit line per entry,
// combinational read, write on the rising edge when we is high.
module main_mem_array
  import cache_def::*;
#(
  parameter int DEPTH_LINES = 4096,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem [DEPTH_LINES];

  // Line write; the store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/cache_main_mem.sv
// Main-memory responder: accepts one line request at a time, answers with a
// one-cycle ready pulse LATENCY cycles after acceptance, and commits writes
// on the edge that raises ready.
module cache_main_mem
  import cache_def::*;
#(
  parameter int DEPTH_LINES = 4096,
  parameter int LATENCY     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy
);

  localparam int IDX_W = $clog2(DEPTH_LINES);

  mem_state_type        state_reg;
  logic [7:0]           lat_cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [LINE_BITS-1:0] wdata_reg;
  logic                 rw_reg;
  logic                 ready_reg;
  logic [LINE_BITS-1:0] rdata_reg;

  logic [LINE_BITS-1:0] array_rdata;
  logic                 commit;
  logic                 array_we;
  logic                 unused_addr;

  // Only the index bits of the address select a line; the rest alias.
  assign unused_addr = ^mem_req.addr;

  // The counter runs LATENCY-1 down to 0 in WAIT; the edge after it reads 0
  // enters RESP, which lands ready exactly LATENCY edges after acceptance.
  assign commit   = (state_reg == MEM_WAIT) && (lat_cnt_reg == 8'd0);
  assign array_we = commit && rw_reg;

  main_mem_array #(
    .DEPTH_LINES(DEPTH_LINES),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (array_we),
    .idx  (idx_reg),
    .wdata(wdata_reg),
    .rdata(array_rdata)
  );

  // Request FSM: capture in IDLE (or on the edge leaving RESP, so a held
  // valid chains straight into the next request), count, respond once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= MEM_IDLE;
      lat_cnt_reg <= 8'd0;
      idx_reg     <= '0;
      wdata_reg   <= '0;
      rw_reg      <= 1'b0;
      ready_reg   <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      case (state_reg)
        MEM_IDLE, MEM_RESP: begin
          ready_reg <= 1'b0;
          if (mem_req.valid) begin
            idx_reg     <= mem_req.addr[LINE_BYTES_LOG2 +: IDX_W];
            wdata_reg   <= mem_req.data;
            rw_reg      <= mem_req.rw;
            lat_cnt_reg <= 8'(LATENCY - 1);
            state_reg   <= MEM_WAIT;
          end else begin
            state_reg   <= MEM_IDLE;
          end
        end
        MEM_WAIT: begin
          if (lat_cnt_reg == 8'd0) begin
            state_reg <= MEM_RESP;
            ready_reg <= 1'b1;
            // Reads return the pre-edge line; write responses keep old data.
            if (!rw_reg) begin
              rdata_reg <= array_rdata;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 8'd1;
          end
        end
        default: begin
          state_reg <= MEM_IDLE;
        end
      endcase
    end
  end

  assign mem_data.data  = rdata_reg;
  assign mem_data.ready = ready_reg;
  assign busy           = (state_reg != MEM_IDLE);

endmodule

// File: tb/tb_cache_main_mem.sv
// Self-checking bench for cache_main_mem: a LATENCY=4 instance and a
// LATENCY=1 instance, checked against a line-indexed reference store.
module tb_cache_main_mem;
  import cache_def::*;

  logic         clk = 1'b0;
  logic         rst_n;
  mem_req_type  req, req1;
  mem_data_type rsp, rsp1;
  logic         busy, busy1;

  int total = 0;
  int bad   = 0;

  // Reference state for the LATENCY=4 instance.
  logic [127:0] model_mem [int];
  logic [127:0] last_read;

  always #5 clk = ~clk;

  cache_main_mem #(.DEPTH_LINES(4096), .LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_req(req), .mem_data(rsp), .busy(busy)
  );

  cache_main_mem #(.DEPTH_LINES(4096), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_data(rsp1), .busy(busy1)
  );

  function automatic int line_of(input logic [31:0] a);
    return int'(a[15:4]);
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one request, scramble the inputs right after acceptance, and
  // report the cycle offset at which ready was seen (-1 if never).
  task automatic issue(input bit fast, input logic rw, input logic [31:0] addr,
                       input logic [127:0] data, output int lat,
                       output logic [127:0] rdata, output logic ready_after);
    mem_req_type r;
    r.valid = 1'b1; r.rw = rw; r.addr = addr; r.data = data;
    @(negedge clk);
    if (fast) req1 = r; else req = r;
    @(posedge clk);
    lat = -1;
    rdata = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        r.valid = 1'b0; r.rw = 1'($urandom); r.addr = $urandom; r.data = rand_line();
        if (fast) req1 = r; else req = r;
      end
      if ((fast ? rsp1.ready : rsp.ready) === 1'b1) begin
        lat = k;
        rdata = fast ? rsp1.data : rsp.data;
        break;
      end
    end
    @(negedge clk);
    ready_after = fast ? rsp1.ready : rsp.ready;
    $display("txn dut=%0d rw=%0d addr=%h lat=%0d data=%h", fast ? 1 : 4, rw, addr, lat, rdata);
  endtask

  task automatic test_reset();
    total++; if (rsp.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", rsp.ready); end
    total++; if (rsp.data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h want=0", rsp.data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b want=0", busy1); end
  endtask

  task automatic test_write_read();
    int lat; logic [127:0] rd; logic ra;
    logic [127:0] d = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    issue(0, 1'b1, 32'h0000_1230, d, lat, rd, ra);
    model_mem[line_of(32'h0000_1230)] = d;
    total++; if (lat !== 4) begin bad++; $display("FAIL wr_latency got=%0d want=4", lat); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL wr_ready_width got=%b want=0", ra); end
    total++; if (rd !== last_read) begin bad++; $display("FAIL wr_data_hold got=%h want=%h", rd, last_read); end
    issue(0, 1'b0, 32'h0000_123C, '0, lat, rd, ra);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd_latency got=%0d want=4", lat); end
    total++; if (rd !== d) begin bad++; $display("FAIL rd_data got=%h want=%h", rd, d); end
    last_read = d;
  endtask

  task automatic test_alias();
    int lat; logic [127:0] rd; logic ra;
    logic [127:0] a = rand_line();
    issue(0, 1'b1, 32'h0001_0040, a, lat, rd, ra);
    model_mem[line_of(32'h0001_0040)] = a;
    issue(0, 1'b0, 32'h0000_0040, '0, lat, rd, ra);
    total++; if (rd !== a) begin bad++; $display("FAIL alias_data got=%h want=%h", rd, a); end
    last_read = a;
  endtask

  // Random mix over a small line pool; the inputs are scrambled during WAIT
  // by issue(), so every response also checks input hold-off.
  task automatic test_random();
    int lat; logic [127:0] rd; logic ra;
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a = $urandom;
      int ln = int'($urandom_range(0, 7)) * 37 + 100;
      a[15:4] = 12'(ln);
      if (model_mem.exists(ln) && ($urandom_range(0, 1) == 1)) begin
        issue(0, 1'b0, a, rand_line(), lat, rd, ra);
        total++; if (rd !== model_mem[ln]) begin bad++; $display("FAIL rand_rd_data got=%h want=%h", rd, model_mem[ln]); end
        last_read = model_mem[ln];
      end else begin
        logic [127:0] d = rand_line();
        issue(0, 1'b1, a, d, lat, rd, ra);
        model_mem[ln] = d;
        total++; if (rd !== last_read) begin bad++; $display("FAIL rand_wr_hold got=%h want=%h", rd, last_read); end
      end
      total++; if (lat !== 4) begin bad++; $display("FAIL rand_latency got=%0d want=4", lat); end
    end
  endtask

  // Write-back then refill with valid held high across the first response.
  task automatic test_back_to_back(input bit fast, input int L);
    mem_req_type r;
    logic [127:0] d = rand_line();
    logic [31:0]  a = $urandom;
    int pulses = 0;
    logic [127:0] got = '0;
    r.valid = 1'b1; r.rw = 1'b1; r.addr = a; r.data = d;
    @(negedge clk);
    if (fast) req1 = r; else req = r;
    @(posedge clk);
    for (int k = 0; k <= 2 * L + 6; k++) begin
      logic rdy, bsy, exp_rdy, exp_busy;
      @(negedge clk);
      rdy = fast ? rsp1.ready : rsp.ready;
      bsy = fast ? busy1 : busy;
      exp_rdy  = (k == L) || (k == 2 * L + 1);
      exp_busy = (k <= 2 * L + 1);
      if (rdy === 1'b1) pulses++;
      if (k == 2 * L + 1) got = fast ? rsp1.data : rsp.data;
      total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL b2b_ready L=%0d k=%0d got=%b want=%b", L, k, rdy, exp_rdy); end
      total++; if (bsy !== exp_busy) begin bad++; $display("FAIL b2b_busy L=%0d k=%0d got=%b want=%b", L, k, bsy, exp_busy); end
      if (k == L) begin r.rw = 1'b0; r.addr = a ^ 32'h0000_000C; r.data = rand_line(); end
      if (k == L + 1) r.valid = 1'b0;
      if (fast) req1 = r; else req = r;
    end
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses L=%0d got=%0d want=2", L, pulses); end
    total++; if (got !== d) begin bad++; $display("FAIL b2b_data L=%0d got=%h want=%h", L, got, d); end
    $display("txn b2b L=%0d addr=%h pulses=%0d data=%h", L, a, pulses, got);
    if (!fast) begin
      model_mem[line_of(a)] = d;
      last_read = d;
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [127:0] rd; logic ra;
    mem_req_type r;
    int pulses = 0;
    logic [127:0] p = rand_line();
    issue(0, 1'b1, 32'h0000_0050, p, lat, rd, ra);
    model_mem[5] = p;
    r.valid = 1'b1; r.rw = 1'b1; r.addr = 32'h0000_0050; r.data = ~p;
    @(negedge clk); req = r;
    @(posedge clk);                 // E0
    @(negedge clk); req.valid = 1'b0;
    @(posedge clk);                 // E0+1
    @(posedge clk);                 // E0+2
    #1 rst_n = 1'b0;
    #1;
    total++; if (rsp.ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", rsp.ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (rsp.data !== 128'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", rsp.data); end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp.ready === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_spurious got=%0d want=0", pulses); end
    last_read = '0;
    issue(0, 1'b0, 32'h0000_0050, '0, lat, rd, ra);
    total++; if (rd !== p) begin bad++; $display("FAIL rst_mid_store got=%h want=%h", rd, p); end
    last_read = p;
  endtask

  task automatic test_latency1();
    int lat; logic [127:0] rd; logic ra;
    logic [127:0] d = rand_line();
    logic [31:0]  a = $urandom;
    issue(1, 1'b1, a, d, lat, rd, ra);
    total++; if (lat !== 1) begin bad++; $display("FAIL l1_wr_latency got=%0d want=1", lat); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL l1_ready_width got=%b want=0", ra); end
    issue(1, 1'b0, a ^ 32'hFFFF_0007, '0, lat, rd, ra);
    total++; if (lat !== 1) begin bad++; $display("FAIL l1_rd_latency got=%0d want=1", lat); end
    total++; if (rd !== d) begin bad++; $display("FAIL l1_rd_data got=%h want=%h", rd, d); end
    test_back_to_back(1'b1, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    req1  = '0;
    last_read = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_write_read();
    test_alias();
    test_random();
    test_back_to_back(1'b0, 4);
    test_reset_mid_write();
    test_latency1();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
